// File: rtl/pc_next_unit_pkg.sv
// Shared definitions for the next-PC generator: control-flow op encodings and size defaults.
package pc_next_unit_pkg;

  localparam int ADDR_W_DEF    = 8;
  localparam int RAS_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    OP_SEQ  = 3'd0,
    OP_BR   = 3'd1,
    OP_JMP  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_HOLD = 3'd5
  } op_e;

endpackage

// File: rtl/pc_next_unit_ret_stack.sv
// Circular hardware return-address stack: push on CALL, pop on RET, sticky overflow/underflow.
module pc_next_unit_ret_stack
  import pc_next_unit_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [ADDR_W-1:0]            push_data_i,
  output logic [ADDR_W-1:0]            top_o,
  output logic [$clog2(RAS_DEPTH):0]   depth_o,
  output logic                         ovf_o,
  output logic                         unf_o
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int DW = PW + 1;
  localparam logic [DW-1:0] FULL = DW'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]     sp_q, sp_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  // The pointer wraps for free because RAS_DEPTH is a power of two; a push
  // onto a full stack silently overwrites the oldest entry.
  always_comb begin
    sp_d    = sp_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (push_i) begin
      sp_d = sp_q + PW'(1);
      if (depth_q == FULL) ovf_d = 1'b1;
      else                 depth_d = depth_q + DW'(1);
    end else if (pop_i) begin
      if (depth_q != '0) begin
        sp_d    = sp_q - PW'(1);
        depth_d = depth_q - DW'(1);
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[sp_q] <= push_data_i;
  end

  assign top_o   = mem_q[sp_q - PW'(1)];
  assign depth_o = depth_q;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

endmodule

// File: rtl/pc_next_unit.sv
// Next-PC mux with increment/branch adder and a return-address stack for CALL/RET.
// Define PC_NEXT_REL_BRANCH_EN to make BR/JMP targets PC-relative signed offsets.
module pc_next_unit
  import pc_next_unit_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            cur_pc,
  input  logic [2:0]                   op,
  input  logic                         br_taken,
  input  logic [ADDR_W-1:0]            target,
  input  logic                         stall,
  output logic [ADDR_W-1:0]            next_pc,
  output logic [$clog2(RAS_DEPTH):0]   ras_depth,
  output logic                         ras_ovf,
  output logic                         ras_unf
);

  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] jump_dest;
  logic [ADDR_W-1:0] ras_top;
  logic              push, pop;

  assign inc = cur_pc + ADDR_W'(1);

`ifdef PC_NEXT_REL_BRANCH_EN
  // Same-width add is the sign-extended offset add modulo 2^ADDR_W.
  assign jump_dest = cur_pc + target;
`else
  assign jump_dest = target;
`endif

  assign push = !stall && (op == OP_CALL);
  assign pop  = !stall && (op == OP_RET);

  always_comb begin
    next_pc = inc;
    if (stall) begin
      next_pc = cur_pc;
    end else begin
      case (op)
        OP_BR:   if (br_taken) next_pc = jump_dest;
        OP_JMP:  next_pc = jump_dest;
        OP_CALL: next_pc = target;
        OP_RET:  if (ras_depth != '0) next_pc = ras_top;
        OP_HOLD: next_pc = cur_pc;
        default: next_pc = inc;
      endcase
    end
  end

  pc_next_unit_ret_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ret_stack (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (inc),
    .top_o       (ras_top),
    .depth_o     (ras_depth),
    .ovf_o       (ras_ovf),
    .unf_o       (ras_unf)
  );

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: directed vector table, hand sequences, then random ops vs a queue model.
module tb_pc_next_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cur_pc;
  logic [2:0] op;
  logic       br_taken;
  logic [7:0] target;
  logic       stall;
  logic [7:0] next_pc;
  logic [2:0] ras_depth;
  logic       ras_ovf;
  logic       ras_unf;

  int n_tests = 0;
  int n_fail  = 0;

  pc_next_unit #(.ADDR_W(8), .RAS_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cur_pc    (cur_pc),
    .op        (op),
    .br_taken  (br_taken),
    .target    (target),
    .stall     (stall),
    .next_pc   (next_pc),
    .ras_depth (ras_depth),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] cur;
    logic [7:0] tgt;
    logic       bt;
    logic       st;
    logic [7:0] exp_next;
    int         exp_depth;
    logic       exp_ovf;
    logic       exp_unf;
  } vec_t;

  vec_t vecs[$];

  // Taken destination of BR/JMP under the configured addressing mode.
  function automatic logic [7:0] jt(input logic [7:0] cur, input logic [7:0] tgt);
`ifdef PC_NEXT_REL_BRANCH_EN
    int s;
    s = int'($signed(tgt));
    return 8'((int'(cur) + s + 256) % 256);
`else
    return tgt;
`endif
  endfunction

  function automatic vec_t mk(input int o, input int c, input int t, input int b, input int s,
                              input int en, input int d, input int ov, input int un);
    vec_t v;
    v.op = 3'(o); v.cur = 8'(c); v.tgt = 8'(t); v.bt = 1'(b); v.st = 1'(s);
    v.exp_next = 8'(en); v.exp_depth = d; v.exp_ovf = 1'(ov); v.exp_unf = 1'(un);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic [7:0] c, input logic [7:0] t,
                       input logic b, input logic s);
    op = o; cur_pc = c; target = t; br_taken = b; stall = s;
  endtask

  // Reference model: return addresses kept newest-last; oldest dropped when full.
  logic [7:0] m_ras[$];
  logic       m_ovf, m_unf;

  function automatic logic [7:0] model_next(input logic [2:0] o, input logic [7:0] c,
                                            input logic [7:0] t, input logic b, input logic s);
    logic [7:0] inc;
    inc = c + 8'd1;
    if (s) return c;
    case (o)
      3'd1:    return b ? jt(c, t) : inc;
      3'd2:    return jt(c, t);
      3'd3:    return t;
      3'd4:    return (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : inc;
      3'd5:    return c;
      default: return inc;
    endcase
  endfunction

  task automatic model_step(input logic [2:0] o, input logic [7:0] c, input logic s);
    logic [7:0] ra;
    if (s) return;
    if (o == 3'd3) begin
      ra = c + 8'd1;
      m_ras.push_back(ra);
      if (m_ras.size() > 4) begin
        void'(m_ras.pop_front());
        m_ovf = 1'b1;
      end
    end else if (o == 3'd4) begin
      if (m_ras.size() > 0) void'(m_ras.pop_back());
      else m_unf = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_depth", ras_depth, 0);
    chk("reset_ovf", ras_ovf, 0);
    chk("reset_unf", ras_unf, 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table: expected next_pc before the edge, stack state after it.
    vecs.push_back(mk(0, 'h00, 'h00, 0, 0, 'h01, 0, 0, 0));
    vecs.push_back(mk(0, 'h01, 'h00, 0, 0, 'h02, 0, 0, 0));
    vecs.push_back(mk(0, 'h02, 'h00, 0, 0, 'h03, 0, 0, 0));
    vecs.push_back(mk(0, 'h03, 'h00, 0, 0, 'h04, 0, 0, 0));
    vecs.push_back(mk(0, 'hFF, 'h00, 0, 0, 'h00, 0, 0, 0));
    vecs.push_back(mk(1, 'h10, 'h40, 1, 0, jt(8'h10, 8'h40), 0, 0, 0));
    vecs.push_back(mk(1, 'h10, 'h40, 0, 0, 'h11, 0, 0, 0));
    vecs.push_back(mk(2, 'h10, 'h80, 0, 0, jt(8'h10, 8'h80), 0, 0, 0));
    vecs.push_back(mk(3, 'h20, 'h50, 0, 0, 'h50, 1, 0, 0));
    vecs.push_back(mk(4, 'h55, 'h00, 0, 0, 'h21, 0, 0, 0));
    vecs.push_back(mk(3, 'h01, 'h60, 0, 0, 'h60, 1, 0, 0));
    vecs.push_back(mk(3, 'h11, 'h60, 0, 0, 'h60, 2, 0, 0));
    vecs.push_back(mk(3, 'h21, 'h60, 0, 0, 'h60, 3, 0, 0));
    vecs.push_back(mk(3, 'h31, 'h60, 0, 0, 'h60, 4, 0, 0));
    vecs.push_back(mk(3, 'h41, 'h60, 0, 0, 'h60, 4, 1, 0));
    vecs.push_back(mk(4, 'h70, 'h00, 0, 0, 'h42, 3, 1, 0));
    vecs.push_back(mk(4, 'h70, 'h00, 0, 0, 'h32, 2, 1, 0));
    vecs.push_back(mk(4, 'h70, 'h00, 0, 0, 'h22, 1, 1, 0));
    vecs.push_back(mk(4, 'h70, 'h00, 0, 0, 'h12, 0, 1, 0));
    vecs.push_back(mk(4, 'h70, 'h00, 0, 0, 'h71, 0, 1, 1));
    vecs.push_back(mk(5, 'h33, 'h99, 1, 0, 'h33, 0, 1, 1));
    vecs.push_back(mk(6, 'h44, 'h99, 1, 0, 'h45, 0, 1, 1));
    vecs.push_back(mk(7, 'hFF, 'h99, 1, 0, 'h00, 0, 1, 1));
    vecs.push_back(mk(2, 'h10, 'h80, 0, 1, 'h10, 0, 1, 1));

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].cur, vecs[i].tgt, vecs[i].bt, vecs[i].st);
      #1;
      chk($sformatf("vec%0d_next", i), next_pc, vecs[i].exp_next);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_depth", i), ras_depth, 32'(vecs[i].exp_depth));
      chk($sformatf("vec%0d_ovf", i), ras_ovf, vecs[i].exp_ovf);
      chk($sformatf("vec%0d_unf", i), ras_unf, vecs[i].exp_unf);
      @(negedge clk);
    end

    // Stall must freeze both next_pc and the stack; async reset clears without a clock.
    for (int k = 0; k < 3; k++) begin
      drive(3'd3, 8'(k + 1), 8'h90, 1'b0, 1'b0);
      @(negedge clk);
    end
    drive(3'd3, 8'h30, 8'h90, 1'b0, 1'b1);
    #1;
    chk("stall_call_next", next_pc, 8'h30);
    @(posedge clk);
    #1;
    chk("stall_call_depth", ras_depth, 3);
    @(negedge clk);
    drive(3'd4, 8'h66, 8'h00, 1'b0, 1'b1);
    #1;
    chk("stall_ret_next", next_pc, 8'h66);
    drive(3'd4, 8'h66, 8'h00, 1'b0, 1'b0);
    #1;
    chk("ret_top_next", next_pc, 8'h04);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_depth", ras_depth, 0);
    chk("async_rst_ovf", ras_ovf, 0);
    chk("async_rst_unf", ras_unf, 0);
    chk("async_rst_ret_next", next_pc, 8'h67);
    @(negedge clk);
    reset = 1'b0;

`ifdef PC_NEXT_REL_BRANCH_EN
    drive(3'd1, 8'h10, 8'hFC, 1'b1, 1'b0);
    #1;
    chk("rel_br_back", next_pc, 8'h0C);
    drive(3'd2, 8'h10, 8'h05, 1'b0, 1'b0);
    #1;
    chk("rel_jmp_fwd", next_pc, 8'h15);
    drive(3'd3, 8'h10, 8'h05, 1'b0, 1'b1);
    #1;
    chk("rel_call_abs", next_pc, 8'h10);
    @(negedge clk);
`endif

    // Randomized ops against the queue model, with occasional async resets.
    m_ras.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [2:0] ro;
      logic [7:0] rc, rt, en;
      logic       rb, rs;
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        #1;
        m_ras.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        chk("rnd_rst_depth", ras_depth, 0);
        reset = 1'b0;
      end
      ro = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(3, 4)) : 3'($urandom_range(0, 7));
      rc = 8'($urandom_range(0, 255));
      rt = 8'($urandom_range(0, 255));
      rb = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 7) == 0);
      drive(ro, rc, rt, rb, rs);
      #1;
      en = model_next(ro, rc, rt, rb, rs);
      chk($sformatf("rnd%0d_next op%0d", n, ro), next_pc, en);
      model_step(ro, rc, rs);
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_depth", n), ras_depth, m_ras.size());
      chk($sformatf("rnd%0d_ovf", n), ras_ovf, m_ovf);
      chk($sformatf("rnd%0d_unf", n), ras_unf, m_unf);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
